// File: rtl/ofdm_seq_pkg.sv
// Shared types and defaults for the OFDM frame sequencer.
// Holds the FSM state encoding, the output load-select codes and a counter sizing helper.
package ofdm_seq_pkg;

  localparam int SAMP_W        = 16;
  localparam int PRE_LEN_DEF   = 128;
  localparam int SYM_LEN_DEF   = 64;
  localparam int GUARD_LEN_DEF = 16;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_PREAMBLE = 3'd1,
    ST_GUARD    = 3'd2,
    ST_PAYLOAD  = 3'd3,
    ST_DONE     = 3'd4
  } seq_state_t;

  typedef enum logic [1:0] {
    LD_NONE = 2'd0,
    LD_PRE  = 2'd1,
    LD_PAY  = 2'd2,
    LD_ZERO = 2'd3
  } ld_sel_t;

  // Bits needed for a counter spanning 0..max(a,b,c)-1.
  function automatic int cnt_width(input int a, input int b, input int c);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (m < 2) m = 2;
    return $clog2(m);
  endfunction

endpackage

// File: rtl/seq_out_stage.sv
// Single registered output stage: loads a preamble, payload or zero sample; 1-cycle latency.
// Holds its sample while downstream stalls; valid drops only after a transfer with no new load.
module seq_out_stage
  import ofdm_seq_pkg::*;
#(
  parameter int W = SAMP_W
) (
  input  logic         i_clock,
  input  logic         i_reset,
  input  logic         i_enable,
  input  logic         i_ready_in,
  input  ld_sel_t      i_ld_sel,
  input  logic [W-1:0] i_pre_data,
  input  logic [W-1:0] i_pay_data,
  output logic [W-1:0] o_out_i,
  output logic         o_out_valid
);

  logic [W-1:0] r_out_i;
  logic         r_out_valid;
  logic [W-1:0] w_ld_dat;

  always_comb begin
    w_ld_dat = '0;
    case (i_ld_sel)
      LD_PRE:  w_ld_dat = i_pre_data;
      LD_PAY:  w_ld_dat = i_pay_data;
      default: w_ld_dat = '0;
    endcase
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_out_i     <= '0;
      r_out_valid <= 1'b0;
    end else if (i_enable) begin
      if (i_ld_sel != LD_NONE) begin
        r_out_i     <= w_ld_dat;
        r_out_valid <= 1'b1;
      end else if (i_ready_in) begin
        r_out_valid <= 1'b0;
      end
    end
  end

  assign o_out_i     = r_out_i;
  assign o_out_valid = r_out_valid;

endmodule

// File: rtl/ofdm_frame_sequencer.sv
// OFDM frame sequencer: preamble, optional zero guard (SEQ_GUARD_EN), then n_sym payload symbols.
// Output is one registered stage; source readies are combinational and only one is ever high.
module ofdm_frame_sequencer
  import ofdm_seq_pkg::*;
#(
  parameter int PRE_LEN   = PRE_LEN_DEF,
  parameter int SYM_LEN   = SYM_LEN_DEF,
  parameter int GUARD_LEN = GUARD_LEN_DEF,
  parameter int SYM_W     = 8
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              enable,
  input  logic              start,
  input  logic [SYM_W-1:0]  n_sym,
  input  logic [SAMP_W-1:0] pre_data,
  input  logic              pre_valid,
  output logic              pre_ready,
  input  logic [SAMP_W-1:0] pay_data,
  input  logic              pay_valid,
  output logic              pay_ready,
  input  logic              ready_in,
  output logic [SAMP_W-1:0] out_i,
  output logic              out_valid,
  output logic              busy,
  output logic              frame_done
);

  localparam int CNT_W = cnt_width(PRE_LEN, SYM_LEN, GUARD_LEN);
  localparam logic [CNT_W-1:0] PRE_LAST = CNT_W'(PRE_LEN - 1);
  localparam logic [CNT_W-1:0] SYM_LAST = CNT_W'(SYM_LEN - 1);

  seq_state_t       r_state;
  logic [CNT_W-1:0] r_samp_cnt;
  logic [SYM_W-1:0] r_sym_cnt;
  logic [SYM_W-1:0] r_n_sym;
  logic             r_busy;
  logic             r_frame_done;

  logic       w_can_load;
  logic       w_pre_acc;
  logic       w_pay_acc;
  logic       w_guard_ld;
  ld_sel_t    w_ld_sel;
  seq_state_t w_after_guard;
  seq_state_t w_after_pre;

  // A new sample may enter only when the output register is empty or draining this cycle.
  assign w_can_load = enable && (!out_valid || ready_in);
  assign pre_ready  = (r_state == ST_PREAMBLE) && w_can_load;
  assign pay_ready  = (r_state == ST_PAYLOAD) && w_can_load;
  assign w_pre_acc  = pre_ready && pre_valid;
  assign w_pay_acc  = pay_ready && pay_valid;

  assign w_after_guard = (r_n_sym == '0) ? ST_DONE : ST_PAYLOAD;
`ifdef SEQ_GUARD_EN
  localparam logic [CNT_W-1:0] GUARD_LAST = CNT_W'(GUARD_LEN - 1);
  assign w_guard_ld  = (r_state == ST_GUARD) && w_can_load;
  assign w_after_pre = ST_GUARD;
`else
  assign w_guard_ld  = 1'b0;
  assign w_after_pre = w_after_guard;
`endif

  always_comb begin
    w_ld_sel = LD_NONE;
    if (w_pre_acc)       w_ld_sel = LD_PRE;
    else if (w_pay_acc)  w_ld_sel = LD_PAY;
    else if (w_guard_ld) w_ld_sel = LD_ZERO;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state      <= ST_IDLE;
      r_samp_cnt   <= '0;
      r_sym_cnt    <= '0;
      r_n_sym      <= '0;
      r_busy       <= 1'b0;
      r_frame_done <= 1'b0;
    end else begin
      r_frame_done <= 1'b0;
      if (enable) begin
        case (r_state)
          ST_IDLE: begin
            if (start) begin
              r_n_sym    <= n_sym;
              r_samp_cnt <= '0;
              r_sym_cnt  <= '0;
              r_busy     <= 1'b1;
              r_state    <= ST_PREAMBLE;
            end
          end
          ST_PREAMBLE: begin
            if (w_pre_acc) begin
              if (r_samp_cnt == PRE_LAST) begin
                r_samp_cnt <= '0;
                r_state    <= w_after_pre;
              end else begin
                r_samp_cnt <= r_samp_cnt + CNT_W'(1);
              end
            end
          end
`ifdef SEQ_GUARD_EN
          ST_GUARD: begin
            if (w_guard_ld) begin
              if (r_samp_cnt == GUARD_LAST) begin
                r_samp_cnt <= '0;
                r_state    <= w_after_guard;
              end else begin
                r_samp_cnt <= r_samp_cnt + CNT_W'(1);
              end
            end
          end
`endif
          ST_PAYLOAD: begin
            if (w_pay_acc) begin
              if (r_samp_cnt == SYM_LAST) begin
                r_samp_cnt <= '0;
                r_sym_cnt  <= r_sym_cnt + SYM_W'(1);
                if (r_sym_cnt + SYM_W'(1) == r_n_sym) r_state <= ST_DONE;
              end else begin
                r_samp_cnt <= r_samp_cnt + CNT_W'(1);
              end
            end
          end
          ST_DONE: begin
            // Hold off the done pulse until the final sample has left the output register.
            if (!out_valid || ready_in) begin
              r_frame_done <= 1'b1;
              r_busy       <= 1'b0;
              r_state      <= ST_IDLE;
            end
          end
          default: r_state <= ST_IDLE;
        endcase
      end
    end
  end

  assign busy       = r_busy;
  assign frame_done = r_frame_done;

  seq_out_stage #(.W(SAMP_W)) u_out_stage (
    .i_clock     (clock),
    .i_reset     (reset),
    .i_enable    (enable),
    .i_ready_in  (ready_in),
    .i_ld_sel    (w_ld_sel),
    .i_pre_data  (pre_data),
    .i_pay_data  (pay_data),
    .o_out_i     (out_i),
    .o_out_valid (out_valid)
  );

endmodule

// File: tb/tb_ofdm_frame_sequencer.sv
// Directed bench for ofdm_frame_sequencer: frame ordering, stalls, n_sym=0, reset mid-frame.
// Expected sample stream is built from the frame parameters; outputs are sampled on the falling edge.
module tb_ofdm_frame_sequencer;

  localparam int PRE = 128;
  localparam int SYM = 64;
`ifdef SEQ_GUARD_EN
  localparam int G = 16;
`else
  localparam int G = 0;
`endif

  logic        clock = 1'b0;
  logic        reset;
  logic        enable;
  logic        start;
  logic [7:0]  n_sym;
  logic [15:0] pre_data;
  logic        pre_valid;
  logic        pre_ready;
  logic [15:0] pay_data;
  logic        pay_valid;
  logic        pay_ready;
  logic        ready_in;
  logic [15:0] out_i;
  logic        out_valid;
  logic        busy;
  logic        frame_done;

  int n_chk = 0;
  int n_err = 0;

  always #5 clock = ~clock;

  ofdm_frame_sequencer dut (
    .clock      (clock),
    .reset      (reset),
    .enable     (enable),
    .start      (start),
    .n_sym      (n_sym),
    .pre_data   (pre_data),
    .pre_valid  (pre_valid),
    .pre_ready  (pre_ready),
    .pay_data   (pay_data),
    .pay_valid  (pay_valid),
    .pay_ready  (pay_ready),
    .ready_in   (ready_in),
    .out_i      (out_i),
    .out_valid  (out_valid),
    .busy       (busy),
    .frame_done (frame_done)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] pre_val(input int k);
    return 16'h1000 + 16'(k);
  endfunction

  function automatic logic [15:0] pay_val(input int k);
    return 16'h5000 + 16'(k);
  endfunction

  function automatic logic [15:0] exp_at(input int p);
    if (p < PRE) return pre_val(p);
    if (p < PRE + G) return 16'h0000;
    return pay_val(p - PRE - G);
  endfunction

  // toggle: ready_in alternates and enable drops for 3 cycles; inject: start pulsed mid-frame;
  // rst_at >= 0: reset asserted while output sample rst_at transfers.
  task automatic run_frame(input string tag, input int nsym, input bit toggle,
                           input bit inject, input int rst_at);
    int exp_len, ncyc, nx, nbad, nhold, ndone, nboth, npay;
    int last_x, done_c, last_pre, first_pay, pre_idx, pay_idx;
    bit fin, was_stall, acc_pre, acc_pay, xfer, rst_hit;
    logic [15:0] held;
    exp_len = PRE + G + nsym * SYM;
    nx = 0; nbad = 0; nhold = 0; ndone = 0; nboth = 0; npay = 0;
    last_x = -1; done_c = -1; last_pre = -1; first_pay = -1;
    pre_idx = 0; pay_idx = 0;
    fin = 0; was_stall = 0; rst_hit = 0; held = '0;
    pre_data = pre_val(0);
    pay_data = pay_val(0);
    n_sym    = 8'(nsym);
    ready_in = 1'b1;
    enable   = 1'b1;
    start    = 1'b1;
    for (ncyc = 0; ncyc < 3000 && !fin; ncyc++) begin
      @(negedge clock);
      if (was_stall && (out_i !== held || out_valid !== 1'b1)) nhold++;
      was_stall = out_valid && (!ready_in || !enable);
      held      = out_i;
      if (ncyc == 1) chk({tag, "_busy"}, {31'd0, busy}, 32'd1);
      if (pre_ready && pay_ready) nboth++;
      if (pay_ready) begin
        npay++;
        if (first_pay < 0) first_pay = ncyc;
      end
      acc_pre = pre_valid && pre_ready;
      acc_pay = pay_valid && pay_ready;
      if (acc_pre) last_pre = ncyc;
      if (frame_done) begin
        ndone++;
        done_c = ncyc;
      end
      xfer = out_valid && ready_in && enable;
      if (xfer) begin
        if (nx >= exp_len || out_i !== exp_at(nx)) nbad++;
        if (rst_at >= 0 && nx == rst_at) begin
          reset   = 1'b1;
          rst_hit = 1;
        end
        nx++;
        last_x = ncyc;
      end
      @(posedge clock);
      #1;
      if (rst_hit) begin
        chk({tag, "_rst_busy"}, {31'd0, busy}, 32'd0);
        chk({tag, "_rst_ovld"}, {31'd0, out_valid}, 32'd0);
        chk({tag, "_rst_prerdy"}, {31'd0, pre_ready}, 32'd0);
        chk({tag, "_rst_nx"}, nx, rst_at + 1);
        chk({tag, "_rst_data"}, nbad, 0);
        reset = 1'b0;
        start = 1'b0;
        return;
      end
      start = inject && (ncyc == 20 || ncyc == 200);
      if (acc_pre) pre_idx++;
      if (acc_pay) pay_idx++;
      pre_data = pre_val(pre_idx);
      pay_data = pay_val(pay_idx);
      ready_in = toggle ? ~ready_in : 1'b1;
      enable   = !(toggle && ncyc >= 50 && ncyc < 53);
      if (done_c >= 0 && ncyc >= done_c + 3) fin = 1;
    end
    chk({tag, "_timeout"}, {31'd0, fin}, 32'd1);
    chk({tag, "_count"}, nx, exp_len);
    chk({tag, "_data"}, nbad, 0);
    chk({tag, "_hold"}, nhold, 0);
    chk({tag, "_done_n"}, ndone, 1);
    chk({tag, "_done_cyc"}, done_c, last_x + 1);
    chk({tag, "_both_rdy"}, nboth, 0);
    chk({tag, "_end_busy"}, {31'd0, busy}, 32'd0);
    chk({tag, "_end_ovld"}, {31'd0, out_valid}, 32'd0);
    if (nsym == 0) chk({tag, "_payrdy_n"}, npay, 0);
    else if (!toggle) chk({tag, "_payrdy_cyc"}, first_pay, last_pre + 1 + G);
  endtask

  initial begin
    reset     = 1'b1;
    enable    = 1'b1;
    start     = 1'b0;
    n_sym     = 8'd0;
    pre_data  = '0;
    pay_data  = '0;
    pre_valid = 1'b1;
    pay_valid = 1'b1;
    ready_in  = 1'b1;
    repeat (3) @(posedge clock);
    #1;
    reset = 1'b0;
    @(negedge clock);
    chk("rst_out_i", {16'd0, out_i}, 32'd0);
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_pre_ready", {31'd0, pre_ready}, 32'd0);
    chk("rst_pay_ready", {31'd0, pay_ready}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_frame_done", {31'd0, frame_done}, 32'd0);
    @(posedge clock);
    #1;

    run_frame("base", 2, 1'b0, 1'b0, -1);
    run_frame("inject", 2, 1'b0, 1'b1, -1);
    run_frame("nsym0", 0, 1'b0, 1'b0, -1);
    run_frame("toggle", 1, 1'b1, 1'b0, -1);
    run_frame("midrst", 1, 1'b0, 1'b0, 70);
    run_frame("replay", 1, 1'b0, 1'b0, -1);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
